// File: rtl/ita_tcdm_responder.sv
// ita_tcdm_responder: MP-bank word-interleaved TCDM memory with per-bank
// round-robin arbitration and one-cycle read latency.
// Optional build macro ITA_TCDM_STALL_EN adds LFSR-driven grant stalls.
// MP and NumWords are expected to be powers of two.
module ita_tcdm_responder #(
    parameter int unsigned MemDataWidth = 64,
    parameter int unsigned MP           = 16,
    parameter int unsigned NumWords     = 256
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [MP-1:0]                         tcdm_req_i,
    output logic [MP-1:0]                         tcdm_gnt_o,
    input  logic [MP-1:0][31:0]                   tcdm_add_i,
    input  logic [MP-1:0]                         tcdm_wen_i,
    input  logic [MP-1:0][MemDataWidth/8-1:0]     tcdm_be_i,
    input  logic [MP-1:0][MemDataWidth-1:0]       tcdm_data_i,
    output logic [MP-1:0][MemDataWidth-1:0]       tcdm_r_data_o,
    output logic [MP-1:0]                         tcdm_r_valid_o
);

    localparam int unsigned BeW   = MemDataWidth / 8;
    localparam int unsigned OffW  = (BeW > 1) ? $clog2(BeW) : 0;
    localparam int unsigned BankW = (MP > 1) ? $clog2(MP) : 1;
    localparam int unsigned RowW  = (NumWords > 1) ? $clog2(NumWords) : 1;

    logic [MemDataWidth-1:0]      mem [MP][NumWords];
    logic [MP-1:0][BankW-1:0]     port_bank;
    logic [MP-1:0][RowW-1:0]      port_row;
    logic [MP-1:0][BankW-1:0]     ptr_q;
    logic [MP-1:0]                win_vld;
    logic [MP-1:0][BankW-1:0]     win_idx;
    logic [MP-1:0]                gnt_c;
    logic [MP-1:0]                r_valid_q;
    logic [MP-1:0][MemDataWidth-1:0] r_data_q;
    logic                         stall_c;
    logic                         grant_en_c;
    logic                         unused_addr_bits;

    // Address bits above the bank/row fields are ignored so addresses wrap.
    assign unused_addr_bits = ^tcdm_add_i;

`ifdef ITA_TCDM_STALL_EN
    logic [15:0] lfsr_q;

    // Fibonacci LFSR (taps 16,14,13,11) that randomly blocks all grants.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign stall_c = (lfsr_q[1:0] == 2'b00);
`else
    assign stall_c = 1'b0;
`endif

    assign grant_en_c = rst_ni & ~stall_c;

    // Split each port address into bank and row fields.
    always_comb begin
        port_bank = '0;
        port_row  = '0;
        for (int unsigned i = 0; i < MP; i++) begin
            port_bank[i] = tcdm_add_i[i][OffW +: BankW];
            port_row[i]  = tcdm_add_i[i][OffW + BankW +: RowW];
        end
    end

    // Per-bank round-robin: first requester at or above the pointer wins.
    always_comb begin
        win_vld = '0;
        win_idx = '0;
        for (int unsigned b = 0; b < MP; b++) begin
            for (int unsigned k = 0; k < MP; k++) begin
                if (!win_vld[b]
                    && tcdm_req_i[BankW'(ptr_q[b] + BankW'(k))]
                    && (port_bank[BankW'(ptr_q[b] + BankW'(k))] == BankW'(b))) begin
                    win_vld[b] = 1'b1;
                    win_idx[b] = BankW'(ptr_q[b] + BankW'(k));
                end
            end
        end
    end

    // Route bank winners back to per-port grants.
    always_comb begin
        gnt_c = '0;
        for (int unsigned b = 0; b < MP; b++) begin
            if (grant_en_c && win_vld[b]) begin
                gnt_c[win_idx[b]] = 1'b1;
            end
        end
    end

    assign tcdm_gnt_o = gnt_c;

    // Byte-enabled bank writes; memory contents survive reset.
    always_ff @(posedge clk_i) begin
        for (int unsigned b = 0; b < MP; b++) begin
            if (grant_en_c && win_vld[b] && !tcdm_wen_i[win_idx[b]]) begin
                for (int unsigned j = 0; j < BeW; j++) begin
                    if (tcdm_be_i[win_idx[b]][j]) begin
                        mem[b][port_row[win_idx[b]]][j*8 +: 8] <= tcdm_data_i[win_idx[b]][j*8 +: 8];
                    end
                end
            end
        end
    end

    // Read responses and round-robin pointer updates.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_valid_q <= '0;
            r_data_q  <= '0;
            ptr_q     <= '0;
        end else begin
            for (int unsigned i = 0; i < MP; i++) begin
                r_valid_q[i] <= gnt_c[i] & tcdm_wen_i[i];
                if (gnt_c[i] && tcdm_wen_i[i]) begin
                    r_data_q[i] <= mem[port_bank[i]][port_row[i]];
                end
            end
            for (int unsigned b = 0; b < MP; b++) begin
                if (grant_en_c && win_vld[b]) begin
                    ptr_q[b] <= BankW'(win_idx[b] + BankW'(1));
                end
            end
        end
    end

    // A response pending across reset assertion is never shown.
    assign tcdm_r_valid_o = r_valid_q & {MP{rst_ni}};
    assign tcdm_r_data_o  = r_data_q;

endmodule

// File: tb/tb_ita_tcdm_responder.sv
// Randomized bench for ita_tcdm_responder against a behavioural bank model.
module tb_ita_tcdm_responder;

    localparam int MP = 16;
    localparam int DW = 64;
    localparam int NW = 256;
    localparam int BW = DW / 8;

    logic                  clk = 1'b0;
    logic                  rst_ni;
    logic [MP-1:0]         tcdm_req_i;
    logic [MP-1:0]         tcdm_gnt_o;
    logic [MP-1:0][31:0]   tcdm_add_i;
    logic [MP-1:0]         tcdm_wen_i;
    logic [MP-1:0][BW-1:0] tcdm_be_i;
    logic [MP-1:0][DW-1:0] tcdm_data_i;
    logic [MP-1:0][DW-1:0] tcdm_r_data_o;
    logic [MP-1:0]         tcdm_r_valid_o;

    always #5 clk = ~clk;

    ita_tcdm_responder #(.MemDataWidth(DW), .MP(MP), .NumWords(NW)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .tcdm_req_i     (tcdm_req_i),
        .tcdm_gnt_o     (tcdm_gnt_o),
        .tcdm_add_i     (tcdm_add_i),
        .tcdm_wen_i     (tcdm_wen_i),
        .tcdm_be_i      (tcdm_be_i),
        .tcdm_data_i    (tcdm_data_i),
        .tcdm_r_data_o  (tcdm_r_data_o),
        .tcdm_r_valid_o (tcdm_r_valid_o)
    );

    typedef struct {
        logic [31:0]   addr;
        logic          wen;
        logic [BW-1:0] be;
        logic [DW-1:0] data;
    } txn_t;

    txn_t          q [MP][$];
    logic [DW-1:0] mem_m [MP][NW];
    int            ptr_m [MP];
    logic [MP-1:0] exp_rv;
    logic [DW-1:0] exp_rd [MP];
    logic [DW-1:0] last_rd [MP];
    logic [15:0]   lfsr_m;
    bit            known;
    int            n_tests;
    int            n_fail;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int bank_of(input logic [31:0] a);
        longint unsigned w = longint'(a) / BW;
        return int'(w % MP);
    endfunction

    function automatic int row_of(input logic [31:0] a);
        longint unsigned w = longint'(a) / BW;
        return int'((w / MP) % NW);
    endfunction

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < MP; i++) n += q[i].size();
        return n;
    endfunction

    task automatic push(input int p, input logic [31:0] a, input logic wen,
                        input logic [BW-1:0] be, input logic [DW-1:0] d);
        txn_t t;
        t.addr = a; t.wen = wen; t.be = be; t.data = d;
        q[p].push_back(t);
    endtask

    // One clock: present queue heads, check DUT against model, advance model.
    task automatic cycle(input logic rst);
        logic [MP-1:0] exp_gnt;
        logic [MP-1:0] new_rv;
        bit            stall;
        int            b;
        int            r;
        int            p;
        @(negedge clk);
        rst_ni = rst;
        for (int i = 0; i < MP; i++) begin
            if (q[i].size() != 0) begin
                tcdm_req_i[i]  = 1'b1;
                tcdm_add_i[i]  = q[i][0].addr;
                tcdm_wen_i[i]  = q[i][0].wen;
                tcdm_be_i[i]   = q[i][0].be;
                tcdm_data_i[i] = q[i][0].data;
            end else begin
                tcdm_req_i[i]  = 1'b0;
                tcdm_add_i[i]  = $urandom;
                tcdm_wen_i[i]  = 1'($urandom);
                tcdm_be_i[i]   = BW'($urandom);
                tcdm_data_i[i] = {$urandom, $urandom};
            end
        end
        #1;
        stall = 1'b0;
`ifdef ITA_TCDM_STALL_EN
        stall = (lfsr_m[1:0] == 2'b00);
`endif
        exp_gnt = '0;
        if (rst && !stall) begin
            for (int bk = 0; bk < MP; bk++) begin
                for (int k = 0; k < MP; k++) begin
                    p = (ptr_m[bk] + k) % MP;
                    if (q[p].size() != 0 && bank_of(q[p][0].addr) == bk) begin
                        exp_gnt[p] = 1'b1;
                        ptr_m[bk]  = (p + 1) % MP;
                        break;
                    end
                end
            end
        end
        check("gnt", 64'(tcdm_gnt_o), 64'(exp_gnt));
        if (known) begin
            check("r_valid", 64'(tcdm_r_valid_o), rst ? 64'(exp_rv) : 64'd0);
            for (int i = 0; i < MP; i++)
                check($sformatf("r_data[%0d]", i), tcdm_r_data_o[i], exp_rd[i]);
        end
        for (int i = 0; i < MP; i++)
            if (tcdm_r_valid_o[i] === 1'b1) last_rd[i] = tcdm_r_data_o[i];
        new_rv = '0;
        for (int i = 0; i < MP; i++) begin
            if (exp_gnt[i] && q[i][0].wen) begin
                new_rv[i] = 1'b1;
                exp_rd[i] = mem_m[bank_of(q[i][0].addr)][row_of(q[i][0].addr)];
            end
        end
        for (int i = 0; i < MP; i++) begin
            if (exp_gnt[i] && !q[i][0].wen) begin
                b = bank_of(q[i][0].addr);
                r = row_of(q[i][0].addr);
                for (int j = 0; j < BW; j++)
                    if (q[i][0].be[j]) mem_m[b][r][j*8 +: 8] = q[i][0].data[j*8 +: 8];
            end
        end
        for (int i = 0; i < MP; i++)
            if (exp_gnt[i]) void'(q[i].pop_front());
        if (rst) begin
            exp_rv = new_rv;
            lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
        end else begin
            exp_rv = '0;
            for (int i = 0; i < MP; i++) begin
                exp_rd[i] = '0;
                ptr_m[i]  = 0;
            end
            lfsr_m = 16'hACE1;
            known  = 1'b1;
        end
    endtask

    // Run until every port queue is empty, then let responses land.
    task automatic drain(input int max_cycles);
        int c = 0;
        while (pending() != 0 && c < max_cycles) begin
            cycle(1'b1);
            c++;
        end
        check("drain_timeout", 64'(pending()), 64'd0);
        for (int i = 0; i < MP; i++) q[i].delete();
        cycle(1'b1);
        cycle(1'b1);
    endtask

    task automatic clear_last();
        for (int i = 0; i < MP; i++) last_rd[i] = '0;
    endtask

    logic [DW-1:0] a0_data;

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        known      = 1'b0;
        lfsr_m     = 16'hACE1;
        exp_rv     = '0;
        rst_ni     = 1'b0;
        tcdm_req_i = '0;
        tcdm_add_i = '0;
        tcdm_wen_i = '0;
        tcdm_be_i  = '0;
        tcdm_data_i = '0;
        for (int i = 0; i < MP; i++) begin
            exp_rd[i] = '0;
            ptr_m[i]  = 0;
        end
        clear_last();

        // Fill every bank row; requests are already presented during reset.
        for (int r = 0; r < NW; r++)
            for (int i = 0; i < MP; i++)
                push(i, 32'((r * MP + i) * BW), 1'b0, '1, {$urandom, $urandom});
        cycle(1'b0);
        cycle(1'b0);
        cycle(1'b0);
        drain(NW * 4 + 200);

        // Single-port write then read-back.
        clear_last();
        push(0, 32'h0, 1'b0, 8'hFF, 64'h1122334455667788);
        push(0, 32'h0, 1'b1, 8'h00, 64'h0);
        drain(50);
        check("wr_rd_port0", last_rd[0], 64'h1122334455667788);

        // All ports hit distinct banks at once.
        clear_last();
        for (int i = 0; i < MP; i++)
            push(i, 32'(32'h100 + 8 * i), 1'b0, 8'hFF, 64'(i) * 64'h0101010101010101);
        for (int i = 0; i < MP; i++)
            push(i, 32'(32'h100 + 8 * i), 1'b1, 8'h00, 64'h0);
        drain(50);
        for (int i = 0; i < MP; i++)
            check($sformatf("all_ports[%0d]", i), last_rd[i], 64'(i) * 64'h0101010101010101);

        // Three ports contend on bank 0.
        for (int n = 0; n < 6; n++) begin
            push(2, 32'h0, 1'b1, 8'h00, 64'h0);
            push(5, 32'h0, 1'b1, 8'h00, 64'h0);
            push(9, 32'h0, 1'b1, 8'h00, 64'h0);
        end
        drain(100);

        // Partial byte-enable write.
        clear_last();
        push(3, 32'h10, 1'b0, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        push(3, 32'h10, 1'b0, 8'h0F, 64'h0);
        push(3, 32'h10, 1'b1, 8'h00, 64'h0);
        drain(50);
        check("byte_enable", last_rd[3], 64'hFFFF_FFFF_0000_0000);

        // Address wrap.
        clear_last();
        push(1, 32'h0, 1'b1, 8'h00, 64'h0);
        drain(50);
        a0_data = last_rd[1];
        clear_last();
        push(1, 32'(BW * MP * NW), 1'b1, 8'h00, 64'h0);
        drain(50);
        check("addr_wrap", last_rd[1], a0_data);

        // Reset right after a read grant suppresses its response.
        push(4, 32'h20, 1'b1, 8'h00, 64'h0);
        for (int c = 0; c < 50 && q[4].size() != 0; c++) cycle(1'b1);
        cycle(1'b0);
        check("rst_rvalid_low", 64'(tcdm_r_valid_o), 64'd0);
        cycle(1'b0);
        push(4, 32'h20, 1'b1, 8'h00, 64'h0);
        drain(50);

        // Randomized traffic with bank contention and stalled requests.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < MP; i++) begin
                if (q[i].size() == 0 && $urandom_range(0, 3) != 0) begin
                    if ($urandom_range(0, 1) == 0)
                        push(i, 32'($urandom_range(0, 63) * BW), 1'($urandom),
                             BW'($urandom), {$urandom, $urandom});
                    else
                        push(i, $urandom, 1'($urandom), BW'($urandom), {$urandom, $urandom});
                end
            end
            cycle(1'b1);
        end
        drain(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ita_tcdm_responder.md
ITA_TCDM_RESPONDER -- requirements
Module: ita_tcdm_responder

Interface
REQ-001 SHALL have parameter MemDataWidth, default 64, width in bits of one port's data word.
REQ-002 SHALL have parameter MP, default 16, number of narrow TCDM slave ports and of memory banks.
REQ-003 SHALL have parameter NumWords, default 256, depth in words of each bank.
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port tcdm_req_i  input  [MP-1:0]  per-port request.
REQ-007 SHALL have port tcdm_gnt_o  output  [MP-1:0]  per-port grant, combinational in the request cycle.
REQ-008 SHALL have port tcdm_add_i  input  [MP-1:0][31:0]  per-port byte address.
REQ-009 SHALL have port tcdm_wen_i  input  [MP-1:0]  1 = read, 0 = write.
REQ-010 SHALL have port tcdm_be_i  input  [MP-1:0][MemDataWidth/8-1:0]  per-port write byte enables.
REQ-011 SHALL have port tcdm_data_i  input  [MP-1:0][MemDataWidth-1:0]  per-port write data.
REQ-012 SHALL have port tcdm_r_data_o  output  [MP-1:0][MemDataWidth-1:0]  per-port read data.
REQ-013 SHALL have port tcdm_r_valid_o  output  [MP-1:0]  per-port read response valid.

Function
REQ-014 SHALL map byte address A to word W = A / (MemDataWidth/8), bank = W mod MP, row = (W / MP) mod NumWords; upper bits ignored (address wraps).
REQ-015 SHALL grant, per bank per cycle, at most one requesting port targeting that bank; tcdm_gnt_o[i] = 0 whenever tcdm_req_i[i] = 0.
REQ-016 SHALL arbitrate each bank round-robin: a per-bank pointer selects the first requester at or above it (wrapping); after a grant the pointer becomes winner+1 mod MP; pointer unchanged when no grant.
REQ-017 SHALL write, on a granted write, only bytes with be set, at the rising edge ending the grant cycle.
REQ-018 SHALL, for a granted read in cycle N, assert tcdm_r_valid_o[i] in cycle N+1 only, with tcdm_r_data_o[i] = row contents as of end of cycle N (before any same-cycle write, which cannot target that bank).
REQ-019 SHALL not assert r_valid for writes; r_data SHALL hold its last value when r_valid is low.
REQ-020 SHALL sustain full throughput: MP ports hitting MP distinct banks are all granted every cycle.
REQ-021 SHALL treat ungranted requests as stalled: no memory effect, no response; the initiator holds the request.

Reset
REQ-022 SHALL, while rst_ni = 0 at a clock edge, clear tcdm_r_valid_o and tcdm_r_data_o to 0 and all round-robin pointers to 0.
REQ-023 SHALL not reset memory contents; a read granted in the cycle before reset asserts SHALL produce no r_valid after reset.
REQ-024 SHALL drive tcdm_gnt_o = 0 for all ports while rst_ni = 0.

Configuration
REQ-025 SHALL compile, when macro ITA_TCDM_STALL_EN is defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 0xACE1, stepping every cycle out of reset); in cycles where LFSR[1:0] = 2'b00 all grants SHALL be 0 and pointers SHALL hold.
REQ-026 SHALL, without ITA_TCDM_STALL_EN, contain no LFSR and grant per REQ-015/016 only.

Verification
REQ-027 Port 0 writes 0x1122334455667788 to 0x0 with be=0xFF, then reads 0x0 -> gnt same cycle each, r_valid[0] one cycle after the read grant, r_data = 0x1122334455667788.
REQ-028 All 16 ports request addresses base+8*i concurrently, pattern i -> all gnt=0xFFFF in one cycle, all r_valid next cycle with correct data.
REQ-029 Ports 2, 5, 9 read 0x0 continuously for 6 cycles -> grants rotate 2,5,9,2,5,9; exactly one r_valid per cycle.
REQ-030 Write 0xFFFF_FFFF_FFFF_FFFF, then write 0x0 with be=0x0F, read -> 0xFFFF_FFFF_0000_0000.
REQ-031 Read at address 8*MP*NumWords returns same data as address 0 (wrap).
REQ-032 Read granted in cycle N, rst_ni low in cycle N+1 -> r_valid stays 0; with ITA_TCDM_STALL_EN, continuous request shows grant gaps yet all responses correct.
